// File: rtl/decode_execute_if.sv
// Bus between the register file / fetch side and the decode-execute unit:
// instruction and operands in, decoded controls and ALU results out.
interface decode_execute_if;
    logic [31:0] instruction;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  branch_type;
    logic        branch_en;
    logic [1:0]  jump;
    logic [2:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic        lt;
    logic        branch_taken;
    logic        halt;
    logic [31:0] result_q;
    logic        zero_q;
    logic        lt_q;
    logic        taken_q;

    modport master (
        output instruction, rs_data, rt_data,
        input  reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write,
        input  branch_type, branch_en, jump, alu_op, alu_ctrl,
        input  alu_result, zero, lt, branch_taken, halt,
        input  result_q, zero_q, lt_q, taken_q
    );

    modport slave (
        input  instruction, rs_data, rt_data,
        output reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write,
        output branch_type, branch_en, jump, alu_op, alu_ctrl,
        output alu_result, zero, lt, branch_taken, halt,
        output result_q, zero_q, lt_q, taken_q
    );
endinterface

// File: rtl/decode_execute_unit.sv
// Single-cycle MIPS-style decode + ALU + branch evaluation, with a one-cycle
// registered copy of the result, flags and branch decision.
module decode_execute_unit (
    input  logic             clk,
    input  logic             reset,
    decode_execute_if.slave  bus
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write;
    logic [2:0]  branch_type;
    logic        branch_en;
    logic [1:0]  jump;
    logic [2:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic        choose_shift;
    logic [31:0] op_a, op_b;
    logic [31:0] alu_result;
    logic        zero, lt, cond, branch_taken;
    logic        unused_reg_fields;

    assign opcode = bus.instruction[31:26];
    assign funct  = bus.instruction[5:0];
    // Register specifiers are consumed by the register file, not here.
    assign unused_reg_fields = &{1'b0, bus.instruction[25:16]};

    always_comb begin
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch_type = 3'd0;
        branch_en   = 1'b0;
        jump        = 2'd0;
        alu_op      = 3'b000;
        case (opcode)
            6'b000000: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 3'b010; end
            6'b001000,
            6'b001001: begin alu_src = 1'b1; reg_write = 1'b1; end
            6'b001100: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 3'b011; end
            6'b001101: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 3'b100; end
            6'b001010: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 3'b101; end
            6'b100011: begin
                alu_src = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
            end
            6'b101011: begin alu_src = 1'b1; mem_write = 1'b1; end
            6'b000100: begin branch_en = 1'b1; alu_op = 3'b001; branch_type = 3'd0; end
            6'b000101: begin branch_en = 1'b1; alu_op = 3'b001; branch_type = 3'd1; end
            6'b000111: begin branch_en = 1'b1; alu_op = 3'b001; branch_type = 3'd2; end
            6'b000001: begin branch_en = 1'b1; alu_op = 3'b001; branch_type = 3'd3; end
            6'b000110: begin branch_en = 1'b1; alu_op = 3'b001; branch_type = 3'd4; end
            6'b010000: begin branch_en = 1'b1; alu_op = 3'b001; branch_type = 3'd5; end
            6'b000010: jump = 2'd1;
            6'b000011: begin jump = 2'd3; reg_write = 1'b1; end
            6'b010010: jump = 2'd2;
            default: ;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            3'b001: alu_ctrl = ALU_SUB;
            3'b011: alu_ctrl = ALU_AND;
            3'b100: alu_ctrl = ALU_OR;
            3'b101: alu_ctrl = ALU_SLT;
            3'b010: begin
                case (funct)
                    6'b100010, 6'b100011: alu_ctrl = ALU_SUB;
                    6'b100100:            alu_ctrl = ALU_AND;
                    6'b100101:            alu_ctrl = ALU_OR;
                    6'b100111:            alu_ctrl = ALU_NOR;
                    6'b101010:            alu_ctrl = ALU_SLT;
                    6'b000000:            alu_ctrl = ALU_SLL;
                    6'b000010:            alu_ctrl = ALU_SRL;
                    default:              alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    assign choose_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL);
    assign op_a = bus.rs_data;
    assign op_b = choose_shift ? {27'd0, bus.instruction[10:6]} :
                  alu_src      ? {{16{bus.instruction[15]}}, bus.instruction[15:0]} :
                                 bus.rt_data;

    // Signed compare runs for every operation so lt is meaningful beyond sub.
    assign lt = $signed(op_a) < $signed(op_b);

    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_NOR: alu_result = ~(op_a | op_b);
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_SLT: alu_result = {31'd0, lt};
            ALU_SLL: alu_result = op_a << op_b[4:0];
            ALU_SRL: alu_result = op_a >> op_b[4:0];
            default: alu_result = 32'd0;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    always_comb begin
        cond = 1'b0;
        case (branch_type)
            3'd0: cond = zero;
            3'd1: cond = ~zero;
            3'd2: cond = ~zero & ~lt;
            3'd3: cond = ~lt;
            3'd4: cond = ~zero & lt;
            3'd5: cond = zero | lt;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = branch_en & cond;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.result_q <= 32'd0;
            bus.zero_q   <= 1'b0;
            bus.lt_q     <= 1'b0;
            bus.taken_q  <= 1'b0;
        end else begin
            bus.result_q <= alu_result;
            bus.zero_q   <= zero;
            bus.lt_q     <= lt;
            bus.taken_q  <= branch_taken;
        end
    end

    assign bus.reg_dst      = reg_dst;
    assign bus.reg_write    = reg_write;
    assign bus.alu_src      = alu_src;
    assign bus.mem_to_reg   = mem_to_reg;
    assign bus.mem_read     = mem_read;
    assign bus.mem_write    = mem_write;
    assign bus.branch_type  = branch_type;
    assign bus.branch_en    = branch_en;
    assign bus.jump         = jump;
    assign bus.alu_op       = alu_op;
    assign bus.alu_ctrl     = alu_ctrl;
    assign bus.alu_result   = alu_result;
    assign bus.zero         = zero;
    assign bus.lt           = lt;
    assign bus.branch_taken = branch_taken;
    assign bus.halt         = (bus.instruction == 32'd0);
endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed-vector bench for decode_execute_unit with hand-computed expectations.
module tb_decode_execute_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    decode_execute_if bus ();
    decode_execute_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.instruction = ins;
        bus.rs_data     = a;
        bus.rt_data     = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] shamt, input logic [5:0] fn);
        return {6'b000000, 5'd1, 5'd2, 5'd3, shamt, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    initial begin
        reset = 1'b1;
        bus.instruction = 32'hFFFF_FFFF;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        #2;
        chk("rst_result_q", bus.result_q, 32'd0);
        chk("rst_zero_q", bus.zero_q, 0);
        chk("rst_taken_q", bus.taken_q, 0);
        chk("halt_nonzero", bus.halt, 0);

        // add
        apply(rtype(5'd0, 6'b100000), 32'd5, 32'd7);
        chk("add_result", bus.alu_result, 32'd12);
        chk("add_zero", bus.zero, 0);
        chk("add_reg_dst", bus.reg_dst, 1);
        chk("add_reg_write", bus.reg_write, 1);
        chk("add_alu_op", bus.alu_op, 3'b010);
        chk("add_alu_ctrl", bus.alu_ctrl, 4'b0010);
        chk("add_q_in_reset", bus.result_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("add_q_before_edge", bus.result_q, 32'd0);
        tick();
        chk("add_result_q", bus.result_q, 32'd12);

        // beq / bne with equal operands
        apply(itype(6'b000100, 16'd4), 32'h1234, 32'h1234);
        chk("beq_alu_ctrl", bus.alu_ctrl, 4'b0110);
        chk("beq_zero", bus.zero, 1);
        chk("beq_taken", bus.branch_taken, 1);
        chk("beq_branch_en", bus.branch_en, 1);
        chk("beq_reg_write", bus.reg_write, 0);
        apply(itype(6'b000101, 16'd4), 32'h1234, 32'h1234);
        chk("bne_type", bus.branch_type, 3'd1);
        chk("bne_taken", bus.branch_taken, 0);

        // signed branches, rs=-3 rt=2
        apply(itype(6'b000110, 16'd4), 32'hFFFF_FFFD, 32'd2);
        chk("blt_lt", bus.lt, 1);
        chk("blt_result", bus.alu_result, 32'hFFFF_FFFB);
        chk("blt_taken", bus.branch_taken, 1);
        tick();
        chk("blt_lt_q", bus.lt_q, 1);
        chk("blt_taken_q", bus.taken_q, 1);
        apply(itype(6'b000111, 16'd4), 32'hFFFF_FFFD, 32'd2);
        chk("bgt_taken", bus.branch_taken, 0);
        apply(itype(6'b010000, 16'd4), 32'hFFFF_FFFD, 32'd2);
        chk("ble_taken", bus.branch_taken, 1);
        apply(itype(6'b000001, 16'd4), 32'hFFFF_FFFD, 32'd2);
        chk("bgte_taken", bus.branch_taken, 0);
        apply(itype(6'b000001, 16'd4), 32'd9, 32'd9);
        chk("bgte_eq_taken", bus.branch_taken, 1);
        apply(itype(6'b000111, 16'd4), 32'd9, 32'd9);
        chk("bgt_eq_taken", bus.branch_taken, 0);

        // immediates and memory
        apply(itype(6'b001010, 16'hFFFF), 32'hFFFF_FFFB, 32'd0);
        chk("slti_alu_ctrl", bus.alu_ctrl, 4'b0111);
        chk("slti_result", bus.alu_result, 32'd1);
        chk("slti_alu_src", bus.alu_src, 1);
        apply(itype(6'b101011, 16'h0008), 32'h100, 32'hDEAD);
        chk("sw_mem_write", bus.mem_write, 1);
        chk("sw_reg_write", bus.reg_write, 0);
        chk("sw_addr", bus.alu_result, 32'h108);
        apply(itype(6'b100011, 16'hFFFC), 32'h100, 32'd0);
        chk("lw_ctrl", {bus.mem_read, bus.mem_to_reg, bus.reg_write, bus.alu_src}, 4'b1111);
        chk("lw_addr", bus.alu_result, 32'hFC);
        apply(itype(6'b001100, 16'h0FF0), 32'hFF00_FF00, 32'd0);
        chk("andi_result", bus.alu_result, 32'h0000_0F00);
        apply(itype(6'b001101, 16'h8001), 32'h12, 32'd0);
        chk("ori_result", bus.alu_result, 32'hFFFF_8013);
        apply(itype(6'b001001, 16'hFFFF), 32'd1, 32'd0);
        chk("addiu_result", bus.alu_result, 32'd0);
        chk("addiu_zero", bus.zero, 1);

        // R-type shifts and logic
        apply(rtype(5'd4, 6'b000000), 32'h0000_000F, 32'h55);
        chk("sll_result", bus.alu_result, 32'h0000_00F0);
        apply(rtype(5'd31, 6'b000010), 32'h8000_0000, 32'h55);
        chk("srl_result", bus.alu_result, 32'd1);
        chk("srl_alu_ctrl", bus.alu_ctrl, 4'b1001);
        apply(rtype(5'd0, 6'b100111), 32'hF0F0_F0F0, 32'h0F0F_0000);
        chk("nor_result", bus.alu_result, 32'h0000_0F0F);
        apply(rtype(5'd0, 6'b100011), 32'd3, 32'd10);
        chk("subu_result", bus.alu_result, 32'hFFFF_FFF9);
        apply(rtype(5'd0, 6'b101010), 32'h7FFF_FFFF, 32'h8000_0000);
        chk("slt_result", bus.alu_result, 32'd0);
        apply(rtype(5'd0, 6'b111111), 32'd2, 32'd3);
        chk("badfunct_add", bus.alu_result, 32'd5);

        // jumps, unknown opcode, halt
        apply(itype(6'b000011, 16'd0), 32'd0, 32'd0);
        chk("jal_jump", bus.jump, 2'd3);
        chk("jal_reg_write", bus.reg_write, 1);
        apply(itype(6'b010010, 16'd0), 32'd0, 32'd0);
        chk("jr_jump", bus.jump, 2'd2);
        apply(itype(6'b000010, 16'd0), 32'd0, 32'd0);
        chk("j_jump", bus.jump, 2'd1);
        apply(itype(6'b111111, 16'hFFFF), 32'd0, 32'd0);
        chk("unk_ctrl", {bus.reg_dst, bus.reg_write, bus.alu_src, bus.mem_to_reg,
                         bus.mem_read, bus.mem_write, bus.branch_en, bus.jump, bus.alu_op}, 0);
        apply(32'd0, 32'd0, 32'd0);
        chk("halt_zero", bus.halt, 1);

        // reset mid-operation
        apply(rtype(5'd0, 6'b100000), 32'd5, 32'd7);
        tick();
        chk("mid_result_q", bus.result_q, 32'd12);
        apply(itype(6'b000100, 16'd4), 32'h1234, 32'h1234);
        tick();
        chk("mid_taken_q", bus.taken_q, 1);
        chk("mid_zero_q", bus.zero_q, 1);
        @(negedge clk);
        bus.instruction = rtype(5'd0, 6'b100000);
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd7;
        #1;
        tick();
        chk("mid_result_q2", bus.result_q, 32'd12);
        #2;
        reset = 1'b1;
        #1;
        chk("async_result_q", bus.result_q, 32'd0);
        chk("async_zero_q", bus.zero_q, 0);
        chk("comb_in_reset", bus.alu_result, 32'd12);
        tick();
        tick();
        chk("held_result_q", bus.result_q, 32'd0);
        chk("held_flags_q", {bus.zero_q, bus.lt_q, bus.taken_q}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_before_edge", bus.result_q, 32'd0);
        tick();
        chk("post_rst_capture", bus.result_q, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_execute_unit.md
# decode_execute_unit

Combined decode-and-execute block for the single-cycle 32-bit MIPS-style processor. It decodes the opcode into datapath control signals, decodes the funct field into an ALU operation, selects the ALU operands, and evaluates the branch condition. The ALU result, flags and branch decision are available combinationally and also through a one-cycle registered copy. It sits between the register file and the data memory / PC-update logic.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock for the output register stage
- reset  in  1  asynchronous, active-high; clears the registered outputs
- instruction  in  32  current instruction word
- rs_data  in  32  register-file read port 1; ALU operand A
- rt_data  in  32  register-file read port 2
- reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write  out  1 each  combinational control signals
- branch_type  out  3  combinational branch condition select
- branch_en  out  1  combinational; instruction is a branch
- jump  out  2  combinational; 0 none, 1 j, 2 jr, 3 jal
- alu_op  out  3  combinational; main-control to ALU-control code
- alu_ctrl  out  4  combinational ALU operation
- alu_result  out  32  combinational ALU output
- zero  out  1  combinational; alu_result == 0
- lt  out  1  combinational; signed(A) < signed(B)
- branch_taken  out  1  combinational; branch_en AND condition
- halt  out  1  combinational; instruction == 32'h0
- result_q, zero_q, lt_q, taken_q  out  32/1/1/1  registered copies of the above

## Operation
- Opcode decode (instruction[31:26]):
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=010.
  - 001000 addi / 001001 addiu: alu_src=1, reg_write=1, alu_op=000.
  - 001100 andi: alu_op=011. 001101 ori: alu_op=100. 001010 slti: alu_op=101. All three set alu_src=1 and reg_write=1.
  - 100011 lw: alu_src=1, mem_to_reg=1, mem_read=1, reg_write=1, alu_op=000.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=000.
  - Branches, all with branch_en=1 and alu_op=001:
    - 000100 beq: branch_type 0.
    - 000101 bne: branch_type 1.
    - 000111 bgt: branch_type 2.
    - 000001 bgte: branch_type 3.
    - 000110 blt: branch_type 4.
    - 010000 ble: branch_type 5.
  - 000010 j: jump=1. 000011 jal: jump=3, reg_write=1. 010010 jr: jump=2.
  - Any other opcode: all control outputs 0.
  - Unlisted signals are 0.
- ALU control:
  - alu_op 000 → add (0010); 001 → sub (0110); 011 → and (0000); 100 → or (0001); 101 → slt (0111).
  - alu_op 010 decodes funct (instruction[5:0]):
    - 100000 and 100001 → add; 100010 and 100011 → sub.
    - 100100 → and; 100101 → or; 100111 → nor (1100); 101010 → slt.
    - 000000 → sll (1000); 000010 → srl (1001).
    - Any other funct → add.
- choose_shift (internal) = 1 only for sll/srl.
- Operand B selection:
  - if choose_shift = 1: zero-extended shamt (instruction[10:6]);
  - else if alu_src = 1: sign-extended instruction[15:0];
  - else: rt_data.
- Operand A is always rs_data.
- ALU operations, all 32-bit with overflow discarded:
  - and: A&B; or: A|B; nor: ~(A|B).
  - add: A+B; sub: A−B.
  - slt: {31'b0, signed A<signed B}.
  - sll: A<<B[4:0]; srl: A>>B[4:0], logical.
  - Undefined alu_ctrl codes produce 0.
- lt is computed as a signed compare for every operation, not only sub.
- Branch condition by branch_type:
  - 0: zero; 1: ~zero.
  - 2: ~zero & ~lt; 3: ~lt.
  - 4: ~zero & lt; 5: zero | lt.
  - 6 and 7: 0.

## Timing
- All decode and ALU paths are purely combinational.
- Registered stage: on each rising clk, result_q/zero_q/lt_q/taken_q capture alu_result/zero/lt/branch_taken. Latency is 1 cycle.
- reset asserted at any time forces result_q=0, zero_q=0, lt_q=0, taken_q=0 immediately, without waiting for a clock edge.
- While reset is held, the registered outputs stay 0. The first capture occurs on the first rising clk after reset deasserts.
- Combinational outputs are unaffected by reset.

## Test plan
- add: R-type funct 100000, rs=5, rt=7 → alu_result=12, zero=0, reg_dst=1, reg_write=1; result_q=12 after one clk.
- beq: opcode 000100, rs=rt=0x1234 → alu_ctrl=0110, zero=1, branch_taken=1. Same instruction with bne → branch_taken=0.
- blt/bgt: rs=−3 (0xFFFFFFFD), rt=2 → lt=1, blt taken=1, bgt taken=0, ble taken=1, bgte taken=0.
- slti with imm 0xFFFF, rs=−5 → operand B=0xFFFFFFFF, alu_result=1. sw → mem_write=1, reg_write=0.
- sll: funct 000000, shamt=4, rs=0x0000000F → alu_result=0x000000F0. srl with shamt=31, rs=0x80000000 → alu_result=1. instruction=0 → halt=1.
- Reset mid-operation: drive add to 12 and clock once (result_q=12), then assert reset between edges → all *_q outputs go to 0 immediately and stay 0 while reset is held across edges.
